fft_reorder_pp: RTL and testbench
=================================

Name: fft_reorder_pp

Overview:
Parametrised mixed-radix index-reorder buffer for the PUSCH FFT/DFT path. It generalises the fixed 25-point 5x5 reorder to any N = N1*N2 transpose permutation. Two memory banks work as a ping-pong pair, so one frame can be written while the previous frame streams out. Valid/ready handshakes run on both sides, with a per-frame bypass mode and frame-boundary markers. It sits between butterfly stages, or at the FFT output, ahead of the resource demapper.

Parameters:
WIDTH, 18, bit width of each of the re and im samples (signed two's complement)
N1, 5, first radix factor; input index k splits as k = k1 + N1*k2
N2, 5, second radix factor; frame length N = N1*N2
AW, $clog2(N1*N2), bank address width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_re  in  WIDTH  signed input real part
in_im  in  WIDTH  signed input imaginary part
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
in_last  in  1  marks sample k = N-1 (checked only, never used for control)
mode  in  1  0 = transpose reorder, 1 = bypass (natural order); sampled with the frame's first sample
out_re  out  WIDTH  signed output real part
out_im  out  WIDTH  signed output imaginary part
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts the sample
out_last  out  1  high with output sample m = N-1
frame_err  out  1  sticky in_last misalignment flag

Behaviour:
- Reset is synchronous and active-high on rst, clocked by clk.
- Reset values:
  - out_valid=0, out_last=0, out_re=0, out_im=0
  - frame_err=0, in_ready=1
  - both banks EMPTY; write bank = 0, read bank = 0
  - all counters 0
- Reset mid-frame discards all buffered data. Memory contents are not cleared.
- Input accept: an input sample is accepted when in_valid && in_ready.
- Write address:
  - Write counters are k1 (0..N1-1) and k2 (0..N2-1).
  - In transpose mode the address is k1*N2 + k2, maintained incrementally. No divider or modulo.
  - Per accept, k1 increments. On wrap, k1 returns to 0 and k2 increments.
  - In bypass mode the address is the linear count.
  - The mode bit is latched per bank on the frame's first accepted sample.
- Bank states: EMPTY, FILLING, FULL, DRAINING.
  - The write bank goes EMPTY -> FILLING on its first accept.
  - It goes FILLING -> FULL on accept of sample N-1. The write pointer then toggles to the other bank.
- in_ready = 1 whenever the current write bank is EMPTY or FILLING.
  - in_ready = 0 when both banks are FULL or DRAINING.
- Read side:
  - The read bank goes FULL -> DRAINING, and is read linearly m = 0..N-1.
  - After the last output handshake it returns to EMPTY and the read pointer toggles.
- Read timing and stall:
  - Memory read is synchronous with 1-cycle latency, followed by a 1-entry output register and skid.
  - Outputs hold stable while out_valid && !out_ready.
  - With out_ready held at 1, throughput is 1 sample/cycle continuous, including across frame boundaries with no bubble.
- Latency: when the read side is idle, out_valid rises for m=0 exactly 2 cycles after the accept of input sample N-1.
- out_last is high only on output m = N-1.
- Simultaneous events:
  - Write completes on one bank while the other bank's final output handshakes in the same cycle: both transitions occur and in_ready stays 1.
  - Any frame accepts in_valid back-to-back with no dead cycle.
- frame_err:
  - Set if in_last=1 on an accepted sample with k != N-1, or if in_last=0 on the accepted sample with k = N-1.
  - Cleared only by rst.
  - The frame is still written and output normally.
- Data passes through bit-exact. No arithmetic or rounding on the data path.

Decomposition:
- Shared package fft_pkg:
  - sample width default
  - mode encodings REORDER_TRANSPOSE=0, REORDER_BYPASS=1
  - bank-state enum EMPTY/FILLING/FULL/DRAINING
- One sub-module: fft_reorder_bank, a simple dual-port 2*N x 2*WIDTH RAM.
  - Synchronous write, synchronous read.
  - Bank select is the address MSB.
- Control (counters, bank FSMs, skid) stays in the top module.

Test Plan:
- N1=N2=5, mode=0, ramp re=k, im=-k for k=0..24, out_ready=1:
  - output re = 0,5,10,15,20,1,6,...,19,24, im negated
  - out_last on the 25th output; out_valid rises 2 cycles after k=24 is accepted.
- N1=4, N2=8, mode=0, ramp 0..31:
  - output re sequence 0,4,8,...,28,1,5,... (out[m] = (m%8)*4 + m/8)
  - no frame_err.
- Three back-to-back frames, mode=1 then 0 then 1, out_ready=1:
  - natural, transposed, natural order with no bubbles
  - in_ready stays 1 throughout.
- out_ready=0 for 60 cycles while feeding frames:
  - two frames accepted, then in_ready=0 on the 51st sample
  - out_re/out_im stay stable, with no loss or duplication once out_ready=1.
- in_last asserted at k=10:
  - frame_err=1 from the next cycle and stays high
  - frame still outputs the correct reorder.
- rst asserted at k=12 of a frame:
  - all outputs return to reset values
  - the next frame from k=0 reorders correctly with no stale data.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared sample width, reorder mode encodings and bank states for the FFT reorder path
package fft_pkg;
    localparam int SAMPLE_W = 18;
    localparam logic REORDER_TRANSPOSE = 1'b0;
    localparam logic REORDER_BYPASS = 1'b1;
    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;
endpackage

// File: rtl/fft_reorder_pp_if.sv
// fft_reorder_pp_if: sample stream in/out handshakes, frame markers and status of the reorder buffer
interface fft_reorder_pp_if #(
    parameter int WIDTH = fft_pkg::SAMPLE_W
);
    logic signed [WIDTH-1:0] in_re, in_im, out_re, out_im;
    logic in_valid, in_ready, in_last, mode;
    logic out_valid, out_ready, out_last, frame_err;
    modport slave (
        input  in_re, in_im, in_valid, in_last, mode, out_ready,
        output in_ready, out_re, out_im, out_valid, out_last, frame_err
    );
    modport master (
        output in_re, in_im, in_valid, in_last, mode, out_ready,
        input  in_ready, out_re, out_im, out_valid, out_last, frame_err
    );
endinterface

// File: rtl/fft_reorder_bank.sv
// fft_reorder_bank: two-bank simple dual-port RAM, bank chosen by the address MSB
module fft_reorder_bank #(
    parameter int DW = 36,
    parameter int N = 25,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW:0]   wa,
    input  logic [DW-1:0] wd,
    input  logic          re,
    input  logic [AW:0]   ra,
    output logic [DW-1:0] rd
);
    logic [DW-1:0] mem [2][N];
    always_ff @(posedge clk) begin
        if (we) mem[wa[AW]][wa[AW-1:0]] <= wd;
        if (re) rd <= mem[ra[AW]][ra[AW-1:0]];
    end
endmodule

// File: rtl/fft_reorder_pp.sv
// fft_reorder_pp: ping-pong N1xN2 transpose/bypass reorder buffer with valid/ready on both sides
module fft_reorder_pp
    import fft_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int N1 = 5,
    parameter int N2 = 5
) (
    input logic clk,
    input logic rst,
    fft_reorder_pp_if.slave io
);
    localparam int N = N1 * N2;
    localparam int AW = $clog2(N);
    localparam int DW = 2 * WIDTH;

    bank_state_e st [2];
    logic wr_bank, iss_bank, mode_q;
    logic [AW-1:0] cnt, k1, k2, taddr, iss_m, wa;
    logic acc, wr_done, s1_adv, iss, iss_last, s1_v, s1_last, load;
    logic [DW-1:0] rdata;

    assign io.in_ready = st[wr_bank] == EMPTY || st[wr_bank] == FILLING;
    assign acc = io.in_valid && io.in_ready;
    assign wr_done = acc && cnt == AW'(N - 1);
    // sample 0 lands on address 0 in both modes, so the not-yet-latched mode is harmless there
    assign wa = mode_q == REORDER_BYPASS ? cnt : taddr;
    assign load = !io.out_valid || io.out_ready;
    assign s1_adv = !s1_v || load;
    assign iss = s1_adv && (st[iss_bank] == FULL || st[iss_bank] == DRAINING);
    assign iss_last = iss_m == AW'(N - 1);

    fft_reorder_bank #(.DW(DW), .N(N), .AW(AW)) u_bank (
        .clk(clk),
        .we(acc),
        .wa({wr_bank, wa}),
        .wd({io.in_re, io.in_im}),
        .re(iss),
        .ra({iss_bank, iss_m}),
        .rd(rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= '{EMPTY, EMPTY};
            wr_bank <= 1'b0;
            iss_bank <= 1'b0;
            mode_q <= 1'b0;
            cnt <= '0;
            k1 <= '0;
            k2 <= '0;
            taddr <= '0;
            iss_m <= '0;
            s1_v <= 1'b0;
            s1_last <= 1'b0;
            io.out_valid <= 1'b0;
            io.out_last <= 1'b0;
            io.out_re <= '0;
            io.out_im <= '0;
            io.frame_err <= 1'b0;
        end else begin
            if (acc) begin
                if (cnt == '0) mode_q <= io.mode;
                if (io.in_last != wr_done) io.frame_err <= 1'b1;
                if (wr_done) begin
                    st[wr_bank] <= FULL;
                    wr_bank <= !wr_bank;
                    cnt <= '0;
                    k1 <= '0;
                    k2 <= '0;
                    taddr <= '0;
                end else begin
                    if (st[wr_bank] == EMPTY) st[wr_bank] <= FILLING;
                    cnt <= cnt + AW'(1);
                    k1 <= k1 == AW'(N1 - 1) ? '0 : k1 + AW'(1);
                    k2 <= k1 == AW'(N1 - 1) ? k2 + AW'(1) : k2;
                    taddr <= k1 == AW'(N1 - 1) ? k2 + AW'(1) : taddr + AW'(N2);
                end
            end
            // a bank is free for writing once its last word has left the RAM; out_last rides the pipeline
            if (iss) begin
                st[iss_bank] <= iss_last ? EMPTY : DRAINING;
                iss_m <= iss_last ? '0 : iss_m + AW'(1);
                if (iss_last) iss_bank <= !iss_bank;
            end
            if (s1_adv) begin
                s1_v <= iss;
                s1_last <= iss && iss_last;
            end
            if (load) begin
                io.out_valid <= s1_v;
                io.out_last <= s1_v && s1_last;
                if (s1_v) begin
                    io.out_re <= rdata[DW-1:WIDTH];
                    io.out_im <= rdata[WIDTH-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_fft_reorder_pp.sv
// tb_fft_reorder_pp: scoreboard bench with a transpose reference model for 5x5 and 4x8 instances
module tb_fft_reorder_pp;
    import fft_pkg::*;
    localparam int W = 18;
    localparam int N = 25;

    typedef struct {
        logic signed [W-1:0] re, im;
        logic last;
    } exp_t;

    logic clk = 0, rst = 1;
    int n_cmp = 0, n_mis = 0;
    exp_t exp_q[$], exp2_q[$], hold, e, e2;
    bit mon_off = 1, chk_cont = 0, expect_ready = 0, stalled = 0, prev_v = 0, done2 = 0;
    logic err_exp = 0;
    int last_k = N - 1;
    int rdy_mode = 0;

    fft_reorder_pp_if #(.WIDTH(W)) bus ();
    fft_reorder_pp_if #(.WIDTH(W)) bus2 ();

    fft_reorder_pp #(.WIDTH(W), .N1(5), .N2(5)) dut (.clk(clk), .rst(rst), .io(bus.slave));
    fft_reorder_pp #(.WIDTH(W), .N1(4), .N2(8)) dut2 (.clk(clk), .rst(rst), .io(bus2.slave));

    always #5 clk = ~clk;

    function automatic int src_idx(int j, int n1, int n2, logic md);
        return md ? j : j / n2 + n1 * (j % n2);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_mis++;
            $display("FAIL %s: got %0d, need %0d", nm, act, expv);
        end
    endtask

    task automatic send(input logic signed [W-1:0] re, input logic signed [W-1:0] im, input logic last, input logic md);
        int t = 0;
        bus.in_re = re;
        bus.in_im = im;
        bus.in_last = last;
        bus.mode = md;
        bus.in_valid = 1'b1;
        if (expect_ready) chk("in_ready_b2b", bus.in_ready, 1);
        while (!bus.in_ready) begin
            @(negedge clk);
            if (++t > 3000) begin
                n_mis++;
                $display("FAIL in_ready_timeout: got 0 for 3000 cycles, need 1");
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
                $fatal(1);
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic md, input bit rnd, input bit gaps, input int upto);
        logic signed [W-1:0] xr [N];
        logic signed [W-1:0] xi [N];
        logic lst;
        int s;
        for (int k = 0; k < upto; k++) begin
            xr[k] = rnd ? W'($urandom) : W'(k);
            xi[k] = rnd ? W'($urandom) : -xr[k];
            lst = (k == last_k);
            if (lst != (k == N - 1)) err_exp = 1'b1;
            if (gaps && $urandom_range(3) == 0) @(negedge clk);
            send(xr[k], xi[k], lst, k == 0 ? md : 1'($urandom));
            if (k == last_k && k != N - 1) chk("frame_err_set", bus.frame_err, 1);
        end
        if (upto == N)
            for (int j = 0; j < N; j++) begin
                s = src_idx(j, 5, 5, md);
                exp_q.push_back('{xr[s], xi[s], j == N - 1});
            end
        chk("frame_err", bus.frame_err, err_exp);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        chk("idle_valid", bus.out_valid, 0);
    endtask

    task automatic chk_reset();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_re", bus.out_re, 0);
        chk("rst_out_im", bus.out_im, 0);
        chk("rst_frame_err", bus.frame_err, 0);
        chk("rst_in_ready", bus.in_ready, 1);
    endtask

    initial begin : rdy_drv
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 : 1'($urandom);
        end
    end

    always @(negedge clk) begin : mon
        if (mon_off) begin
            stalled = 0;
            prev_v = 0;
        end else begin
            if (stalled) begin
                n_cmp++;
                if (!(bus.out_valid === 1'b1 && bus.out_re === hold.re && bus.out_im === hold.im && bus.out_last === hold.last)) begin
                    n_mis++;
                    $display("FAIL hold: got v=%0b re=%0d im=%0d last=%0b, need v=1 re=%0d im=%0d last=%0b",
                             bus.out_valid, bus.out_re, bus.out_im, bus.out_last, hold.re, hold.im, hold.last);
                end
            end
            if (chk_cont && prev_v && exp_q.size() > 0) chk("no_bubble", bus.out_valid, 1);
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL unexpected_out: got re=%0d im=%0d, need no output", bus.out_re, bus.out_im);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_re !== e.re || bus.out_im !== e.im || bus.out_last !== e.last) begin
                        n_mis++;
                        $display("FAIL out_data: got re=%0d im=%0d last=%0b, need re=%0d im=%0d last=%0b",
                                 bus.out_re, bus.out_im, bus.out_last, e.re, e.im, e.last);
                    end
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            hold = '{bus.out_re, bus.out_im, bus.out_last};
            prev_v = bus.out_valid;
        end
    end

    always @(negedge clk) begin : mon2
        if (!rst && bus2.out_valid && bus2.out_ready) begin
            n_cmp++;
            if (exp2_q.size() == 0) begin
                n_mis++;
                $display("FAIL unexpected_out_4x8: got re=%0d, need no output", bus2.out_re);
            end else begin
                e2 = exp2_q.pop_front();
                if (bus2.out_re !== e2.re || bus2.out_im !== e2.im || bus2.out_last !== e2.last) begin
                    n_mis++;
                    $display("FAIL out_4x8: got re=%0d im=%0d last=%0b, need re=%0d im=%0d last=%0b",
                             bus2.out_re, bus2.out_im, bus2.out_last, e2.re, e2.im, e2.last);
                end
            end
        end
    end

    initial begin : drv2
        bus2.in_valid = 0;
        bus2.in_last = 0;
        bus2.mode = REORDER_TRANSPOSE;
        bus2.in_re = 0;
        bus2.in_im = 0;
        bus2.out_ready = 1;
        @(negedge clk);
        while (rst) @(negedge clk);
        for (int j = 0; j < 32; j++) exp2_q.push_back('{W'(src_idx(j, 4, 8, 0)), -W'(src_idx(j, 4, 8, 0)), j == 31});
        for (int k = 0; k < 32; k++) begin
            bus2.in_re = W'(k);
            bus2.in_im = -W'(k);
            bus2.in_last = (k == 31);
            bus2.in_valid = 1;
            chk("in_ready_4x8", bus2.in_ready, 1);
            @(negedge clk);
        end
        bus2.in_valid = 0;
        for (int t = 0; t < 200 && exp2_q.size() != 0; t++) @(negedge clk);
        chk("drain_4x8", exp2_q.size(), 0);
        chk("frame_err_4x8", bus2.frame_err, 0);
        done2 = 1;
    end

    initial begin : main
        int t;
        bus.in_valid = 0;
        bus.in_last = 0;
        bus.mode = REORDER_TRANSPOSE;
        bus.in_re = 0;
        bus.in_im = 0;
        repeat (3) @(negedge clk);
        chk_reset();
        rst = 0;
        @(negedge clk);
        mon_off = 0;
        // ramp through the 5x5 transpose, with first-output latency
        send_frame(REORDER_TRANSPOSE, 0, 0, N);
        chk("lat_0", bus.out_valid, 0);
        @(negedge clk);
        chk("lat_1", bus.out_valid, 0);
        @(negedge clk);
        chk("lat_2", bus.out_valid, 1);
        drain();
        // three back-to-back frames, bypass / transpose / bypass
        expect_ready = 1;
        chk_cont = 1;
        send_frame(REORDER_BYPASS, 1, 0, N);
        send_frame(REORDER_TRANSPOSE, 1, 0, N);
        send_frame(REORDER_BYPASS, 1, 0, N);
        drain();
        expect_ready = 0;
        chk_cont = 0;
        // downstream stall while two frames fill both banks
        rdy_mode = 1;
        repeat (2) @(negedge clk);
        send_frame(REORDER_TRANSPOSE, 1, 0, N);
        send_frame(REORDER_BYPASS, 1, 0, N);
        chk("in_ready_full", bus.in_ready, 0);
        repeat (8) @(negedge clk);
        rdy_mode = 0;
        send_frame(REORDER_TRANSPOSE, 1, 0, N);
        drain();
        // random frames under random backpressure and input gaps
        rdy_mode = 2;
        for (int f = 0; f < 8; f++) send_frame(1'($urandom), 1, 1, N);
        rdy_mode = 0;
        drain();
        // misplaced in_last: early at k=10, missing at k=24
        last_k = 10;
        send_frame(REORDER_TRANSPOSE, 1, 0, N);
        last_k = N - 1;
        drain();
        chk("frame_err_sticky", bus.frame_err, 1);
        t = 0;
        while (!done2 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("done_4x8", done2, 1);
        // reset mid-frame with a stalled output frame in flight
        rdy_mode = 1;
        repeat (2) @(negedge clk);
        send_frame(REORDER_TRANSPOSE, 1, 0, N);
        send_frame(REORDER_TRANSPOSE, 1, 0, 12);
        mon_off = 1;
        @(negedge clk);
        rst = 1;
        exp_q.delete();
        rdy_mode = 0;
        @(negedge clk);
        chk_reset();
        rst = 0;
        err_exp = 0;
        @(negedge clk);
        mon_off = 0;
        send_frame(REORDER_TRANSPOSE, 0, 0, N);
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
